bio_ahbs_sram: RTL and testbench

// - AHB-Lite subordinate (responder) with local word-addressed SRAM; the far end of the BIO BDMA AHB manager port.
// - Lets the BDMA engine be simulated and FPGA-tested standalone; the responder completes every accepted transfer.
// - Supports OKAY responses with programmable wait states and the two-cycle ERROR response.

---
 rtl/bio_ahbs_pkg.sv | 34 +++
 rtl/bio_ahbs_sram_if.sv | 28 ++
 rtl/bio_ahbs_mem.sv | 31 +++
 rtl/bio_ahbs_sram.sv | 146 ++++++++++++++
 tb/tb_bio_ahbs_sram.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bio_ahbs_pkg.sv
// Shared types for the BIO AHB-Lite SRAM responder: transfer codes, size codes, FSM states
// and the byte-strobe decode.
package bio_ahbs_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } fsm_e;

    // Little-endian lane enables; illegal sizes enable nothing.
    function automatic logic [3:0] strb(input logic [1:0] addr, input logic [2:0] size);
        case (size)
            SZ_B:    strb = 4'b0001 << addr;
            SZ_H:    strb = addr[1] ? 4'b1100 : 4'b0011;
            SZ_W:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/bio_ahbs_sram_if.sv
// AHB-Lite bus bundle between the BDMA manager port and the SRAM responder.
interface bio_ahbs_sram_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          hsel;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [AW-1:0] haddr;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic          hmasterlock;
    logic [DW-1:0] hwdata;
    logic          hreadym;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic          hresp;

    modport master (
        output hsel, htrans, hwrite, haddr, hsize, hburst, hmasterlock, hwdata, hreadym,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, htrans, hwrite, haddr, hsize, hburst, hmasterlock, hwdata, hreadym,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/bio_ahbs_mem.sv
// Word-wide synchronous SRAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module bio_ahbs_mem #(
    parameter int DEPTH = 1024,
    parameter int IW    = 10
) (
    input  logic          clk_i,
    input  logic [3:0]    we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [IW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Read-before-write on a same-address collision; the top forwards the new bytes.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/bio_ahbs_sram.sv
// AHB-Lite responder with local word SRAM, programmable wait states and two-cycle ERROR.
// Defining BIO_AHBS_ERRINJ_EN adds err_inj_i, which forces an accepted transfer to ERROR.
module bio_ahbs_sram
    import bio_ahbs_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int WAITS = 0
) (
    input  logic aclk_i,
    input  logic reset_n_i,
`ifdef BIO_AHBS_ERRINJ_EN
    input  logic err_inj_i,
`endif
    bio_ahbs_sram_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fsm_e          state_q, state_d;
    logic [2:0]    waitCnt_q, waitCnt_d;
    logic          isWrite_q;
    logic [IW-1:0] wrIdx_q;
    logic [3:0]    wrStrb_q;
    logic [3:0]    fwdStrb_q;
    logic [DW-1:0] fwdData_q;

    logic          accept, canTake, taken, illegal, errInj, rdIssue, hazard;
    logic          hready, hresp;
    logic [IW-1:0] reqIdx;
    logic [3:0]    reqStrb, memWe;
    logic [DW-1:0] memRdata, rdMerged;
    logic          unusedBus;

`ifdef BIO_AHBS_ERRINJ_EN
    assign errInj = err_inj_i;
`else
    assign errInj = 1'b0;
`endif

    assign unusedBus = ^{bus.hburst, bus.hmasterlock, bus.htrans[0]};

    assign accept  = bus.hsel & bus.htrans[1] & bus.hreadym;
    assign canTake = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign taken   = accept & canTake;
    assign reqIdx  = bus.haddr[IW+1:2];
    assign reqStrb = strb(bus.haddr[1:0], bus.hsize);

    always_comb begin
        illegal = errInj;
        if (bus.hsize > SZ_W) illegal = 1'b1;
        if ((bus.hsize == SZ_H) && bus.haddr[0]) illegal = 1'b1;
        if ((bus.hsize == SZ_W) && (bus.haddr[1:0] != 2'b00)) illegal = 1'b1;
        if (bus.haddr[AW-1:2] >= (AW-2)'(DEPTH)) illegal = 1'b1;
    end

    assign memWe   = ((state_q == ST_DATA) && isWrite_q) ? wrStrb_q : 4'b0000;
    assign rdIssue = taken & ~illegal & ~bus.hwrite;
    assign hazard  = (memWe != 4'b0000) && (wrIdx_q == reqIdx);

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        hready    = 1'b1;
        hresp     = 1'b0;
        case (state_q)
            ST_WAIT: begin
                hready = 1'b0;
                if (waitCnt_q == 3'd0) state_d = ST_DATA;
                else                   waitCnt_d = waitCnt_q - 3'd1;
            end
            ST_ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = ST_ERR2;
            end
            default: begin
                hresp   = (state_q == ST_ERR2);
                state_d = ST_IDLE;
                if (taken) begin
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WAITS == 0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d   = ST_WAIT;
                        waitCnt_d = 3'(WAITS - 1);
                    end
                end
            end
        endcase
    end

    // A read colliding with a committing write latches the new bytes for merging.
    always_ff @(posedge aclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            waitCnt_q <= 3'd0;
            isWrite_q <= 1'b0;
            wrIdx_q   <= '0;
            wrStrb_q  <= 4'b0000;
            fwdStrb_q <= 4'b0000;
            fwdData_q <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            if (taken) begin
                isWrite_q <= bus.hwrite & ~illegal;
                wrIdx_q   <= reqIdx;
                wrStrb_q  <= reqStrb;
            end else if (state_q == ST_DATA) begin
                isWrite_q <= 1'b0;
            end
            if (rdIssue) begin
                fwdStrb_q <= hazard ? memWe : 4'b0000;
                fwdData_q <= bus.hwdata;
            end
        end
    end

    always_comb begin
        rdMerged = '0;
        if ((state_q == ST_DATA) && !isWrite_q) begin
            for (int b = 0; b < 4; b++) begin
                rdMerged[8*b +: 8] = fwdStrb_q[b] ? fwdData_q[8*b +: 8] : memRdata[8*b +: 8];
            end
        end
    end

    assign bus.hrdata = rdMerged;
    assign bus.hready = hready;
    assign bus.hresp  = hresp;

    bio_ahbs_mem #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk_i   (aclk_i),
        .we_i    (memWe),
        .waddr_i (wrIdx_q),
        .wdata_i (bus.hwdata),
        .re_i    (rdIssue),
        .raddr_i (reqIdx),
        .rdata_o (memRdata)
    );
endmodule

// File: tb/tb_bio_ahbs_sram.sv
// Randomised bench for bio_ahbs_sram: two responders (0 and 3 wait states) driven by a
// pipelined AHB manager and checked against an in-order byte-addressed memory model.
module tb_bio_ahbs_sram;
    import bio_ahbs_pkg::*;

    localparam int DEPTH   = 1024;
    localparam int WAITS_B = 3;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          err;
    } txn_t;

    logic aclk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;
    int   act      = 0;

    logic        tSel;
    logic [1:0]  tTrans;
    logic        tWrite;
    logic [31:0] tAddr;
    logic [2:0]  tSize;
    logic [2:0]  tBurst;
    logic        tLock;
    logic [31:0] tWdata;
`ifdef BIO_AHBS_ERRINJ_EN
    logic        tErr;
`endif

    txn_t        txnQ[$];
    logic [31:0] refMem [int];

    bio_ahbs_sram_if #(.AW(32), .DW(32)) busA ();
    bio_ahbs_sram_if #(.AW(32), .DW(32)) busB ();

    assign busA.hsel        = tSel && (act == 0);
    assign busA.htrans      = tTrans;
    assign busA.hwrite      = tWrite;
    assign busA.haddr       = tAddr;
    assign busA.hsize       = tSize;
    assign busA.hburst      = tBurst;
    assign busA.hmasterlock = tLock;
    assign busA.hwdata      = tWdata;
    assign busA.hreadym     = busA.hready;

    assign busB.hsel        = tSel && (act == 1);
    assign busB.htrans      = tTrans;
    assign busB.hwrite      = tWrite;
    assign busB.haddr       = tAddr;
    assign busB.hsize       = tSize;
    assign busB.hburst      = tBurst;
    assign busB.hmasterlock = tLock;
    assign busB.hwdata      = tWdata;
    assign busB.hreadym     = busB.hready;

    logic        actReady, actResp;
    logic [31:0] actRdata;
    assign actReady = (act == 0) ? busA.hready : busB.hready;
    assign actResp  = (act == 0) ? busA.hresp  : busB.hresp;
    assign actRdata = (act == 0) ? busA.hrdata : busB.hrdata;

    bio_ahbs_sram #(.AW(32), .DW(32), .DEPTH(DEPTH), .WAITS(0)) dutA (
        .aclk_i    (aclk),
        .reset_n_i (reset_n),
`ifdef BIO_AHBS_ERRINJ_EN
        .err_inj_i (tErr),
`endif
        .bus       (busA)
    );

    bio_ahbs_sram #(.AW(32), .DW(32), .DEPTH(DEPTH), .WAITS(WAITS_B)) dutB (
        .aclk_i    (aclk),
        .reset_n_i (reset_n),
`ifdef BIO_AHBS_ERRINJ_EN
        .err_inj_i (tErr),
`endif
        .bus       (busB)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic finishRun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic int keyOf(input logic [31:0] addr);
        return act * 65536 + int'(addr >> 2);
    endfunction

    // Error rules from the bus protocol, independent of how the responder decodes them.
    function automatic bit isError(input txn_t t);
        if (t.err) return 1'b1;
        if (t.size > 3'd2) return 1'b1;
        if ((t.addr % (32'd1 << t.size)) != 0) return 1'b1;
        if ((t.addr >> 2) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    task automatic driveIdle();
        tSel = 1'b0; tTrans = HT_IDLE; tWrite = 1'b0; tAddr = '0;
        tSize = SZ_B; tBurst = '0; tLock = 1'b0;
`ifdef BIO_AHBS_ERRINJ_EN
        tErr = 1'b0;
`endif
    endtask

    task automatic driveAddr(input txn_t t);
        tSel = t.sel; tTrans = t.trans; tWrite = t.write; tAddr = t.addr;
        tSize = t.size; tBurst = 3'($urandom_range(0, 7)); tLock = 1'($urandom_range(0, 1));
`ifdef BIO_AHBS_ERRINJ_EN
        tErr = t.err;
`endif
    endtask

    task automatic addTxn(input bit write, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, input bit err = 1'b0,
                          input logic [1:0] trans = HT_NONSEQ);
        txn_t t;
        t.sel = 1'b1; t.trans = trans; t.write = write; t.addr = addr;
        t.size = size; t.wdata = wdata; t.err = err;
        txnQ.push_back(t);
    endtask

    task automatic finishPhase(input txn_t t, input int waitC, input int errC,
                               input logic resp, input logic [31:0] rd);
        bit          err;
        int          k, expWait, lo, n;
        logic [31:0] w;
        err     = isError(t);
        k       = keyOf(t.addr);
        expWait = err ? 0 : ((act == 0) ? 0 : WAITS_B);
        checkOutput(t.write ? "wrResp" : "rdResp",
                    64'({waitC[7:0], errC[7:0], 7'b0, resp}),
                    64'({expWait[7:0], (err ? 8'd1 : 8'd0), 7'b0, err}));
        if (!err && t.write) begin
            w  = refMem.exists(k) ? refMem[k] : 32'h0;
            lo = int'(t.addr[1:0]);
            n  = 1 << t.size;
            for (int b = 0; b < 4; b++) begin
                if (b >= lo && b < lo + n) w[8*b +: 8] = t.wdata[8*b +: 8];
            end
            refMem[k] = w;
        end else if (!err && refMem.exists(k)) begin
            checkOutput("rdData", 64'(rd), 64'(refMem[k]));
        end
    endtask

    // Pipelined manager: address phase of one transfer overlaps the data phase of the previous.
    task automatic applyStimulus();
        txn_t        ap, dp;
        bit          apPresent, dpValid;
        int          waitC, errC, guard;
        logic        rdy, resp;
        logic [31:0] rd;
        apPresent = 1'b0; dpValid = 1'b0; waitC = 0; errC = 0; guard = 0;
        if (txnQ.size() != 0) begin
            ap = txnQ.pop_front(); driveAddr(ap); apPresent = 1'b1;
        end else begin
            driveIdle();
        end
        while (apPresent || dpValid) begin
            @(negedge aclk);
            rdy = actReady; resp = actResp; rd = actRdata;
            if (dpValid) begin
                if (rdy)       finishPhase(dp, waitC, errC, resp, rd);
                else if (resp) errC++;
                else           waitC++;
            end else begin
                checkOutput("idleOkay", 64'({rdy, resp}), 64'(2'b10));
            end
            if (rdy) guard = 0;
            else     guard++;
            if (guard > 20) begin
                checkOutput("timeout", 64'(guard), 64'(0));
                finishRun();
            end
            @(posedge aclk);
            #1;
            if (rdy) begin
                dpValid = apPresent && ap.sel && ap.trans[1];
                dp = ap; waitC = 0; errC = 0;
                tWdata = (dpValid && dp.write) ? dp.wdata : $urandom;
                if (txnQ.size() != 0) begin
                    ap = txnQ.pop_front(); driveAddr(ap); apPresent = 1'b1;
                end else begin
                    driveIdle(); apPresent = 1'b0;
                end
            end
        end
    endtask

    task automatic initWindow();
        for (int w = 0; w < 16; w++) addTxn(1'b1, 32'(4 * w), SZ_W, $urandom);
        addTxn(1'b1, 32'(4 * (DEPTH - 1)), SZ_W, $urandom);
        applyStimulus();
    endtask

    task automatic genRandom(input int n);
        for (int i = 0; i < n; i++) begin
            txn_t t;
            int   r;
            r       = $urandom_range(0, 99);
            t.sel   = ($urandom_range(0, 19) != 0);
            t.trans = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? HT_BUSY : HT_IDLE)
                                                  : ((i % 4 != 0) ? HT_SEQ : HT_NONSEQ);
            t.write = 1'($urandom_range(0, 1));
            t.size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if (r < 80)      t.addr = 32'($urandom_range(0, 63));
            else if (r < 90) t.addr = 32'(4 * DEPTH + $urandom_range(0, 4095));
            else             t.addr = 32'(4 * (DEPTH - 1) + $urandom_range(0, 3));
            if (t.size <= 3'd2 && $urandom_range(0, 3) != 0) t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
            t.wdata = $urandom;
`ifdef BIO_AHBS_ERRINJ_EN
            t.err   = ($urandom_range(0, 9) == 0);
`else
            t.err   = 1'b0;
`endif
            txnQ.push_back(t);
        end
        applyStimulus();
    endtask

    initial begin
        driveIdle();
        tWdata  = '0;
        reset_n = 1'b0;
        #3;
        checkOutput("rstA", 64'({busA.hready, busA.hresp, busA.hrdata}), 64'({1'b1, 1'b0, 32'h0}));
        checkOutput("rstB", 64'({busB.hready, busB.hresp, busB.hrdata}), 64'({1'b1, 1'b0, 32'h0}));
        @(negedge aclk);
        @(negedge aclk);
        reset_n = 1'b1;
        @(posedge aclk);
        #1;

        act = 0;
        addTxn(1'b1, 32'h10, SZ_W, 32'hDEADBEEF);
        addTxn(1'b0, 32'h10, SZ_W, 32'h0);
        applyStimulus();
        initWindow();

        addTxn(1'b1, 32'h10, SZ_W, 32'h11223344);
        addTxn(1'b1, 32'h13, SZ_B, {8'hAA, 24'($urandom)});
        addTxn(1'b0, 32'h10, SZ_W, 32'h0);
        applyStimulus();

        addTxn(1'b1, 32'h01, SZ_H, 32'hFFFFFFFF);
        addTxn(1'b0, 32'h04, 3'd3, 32'h0);
        addTxn(1'b1, 32'(4 * DEPTH), SZ_W, 32'hFFFFFFFF);
        addTxn(1'b0, 32'h00, SZ_W, 32'h0);
        addTxn(1'b0, 32'h04, SZ_W, 32'h0);
        applyStimulus();

`ifdef BIO_AHBS_ERRINJ_EN
        addTxn(1'b1, 32'h30, SZ_W, 32'hA1A1A1A1, 1'b0, HT_NONSEQ);
        addTxn(1'b1, 32'h34, SZ_W, 32'hB2B2B2B2, 1'b1, HT_SEQ);
        addTxn(1'b1, 32'h38, SZ_W, 32'hC3C3C3C3, 1'b0, HT_SEQ);
        addTxn(1'b1, 32'h3C, SZ_W, 32'hD4D4D4D4, 1'b0, HT_SEQ);
        for (int w = 12; w < 16; w++) addTxn(1'b0, 32'(4 * w), SZ_W, 32'h0);
        applyStimulus();
`endif

        genRandom(200);

        act = 1;
        initWindow();
        addTxn(1'b0, 32'h10, SZ_W, 32'h0);
        applyStimulus();
        genRandom(80);

        tSel = 1'b1; tTrans = HT_NONSEQ; tWrite = 1'b1; tAddr = 32'h20; tSize = SZ_W;
        @(posedge aclk);
        #1;
        driveIdle();
        tWdata = ~refMem[keyOf(32'h20)];
        @(negedge aclk);
        checkOutput("rstWait", 64'({actReady, actResp}), 64'(2'b00));
        reset_n = 1'b0;
        #1;
        checkOutput("rstAsync", 64'({actReady, actResp, actRdata}), 64'({1'b1, 1'b0, 32'h0}));
        @(posedge aclk);
        @(posedge aclk);
        #1;
        reset_n = 1'b1;
        addTxn(1'b0, 32'h20, SZ_W, 32'h0);
        applyStimulus();
        genRandom(20);

        finishRun();
    end
endmodule
